// File: rtl/risc_v_mike_pkg.sv
// Shared constants for the risc_v_mike GPIO slice.
//   GPIO_BYTE       : width of the GPIO pin bank.
//   debounce_cnt_w(): width of a debounce counter for a given stable-cycle count.
package risc_v_mike_pkg;

  localparam int unsigned GPIO_BYTE = 8;

  // Counter must hold 0..DEBOUNCE_CYCLES; never narrower than one bit.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/risc_v_mike_debounce_bit.sv
// Single-pin debouncer: two-flop synchronizer, stability counter, clean level
// and registered one-cycle edge pulses aligned with the clean-level change.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   pin_in     : raw asynchronous pin
//   clean      : debounced level
//   rise_pulse : one cycle, on accepted 0->1
//   fall_pulse : one cycle, on accepted 1->0
module risc_v_mike_debounce_bit
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_q != clean);
  assign accept = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= pin_in;
      sync_q    <= sync_meta;
    end
  end

  // Any cycle where the synchronized level matches the clean level restarts
  // the count, so only an unbroken run of DEBOUNCE_CYCLES differing cycles
  // is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      clean      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept &  sync_q;
      fall_pulse <= accept & ~sync_q;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        clean <= sync_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/risc_v_mike_gpio_debounce.sv
// GPIO input conditioning: per-pin debouncers plus sticky edge interrupt flags.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   gpio_pin_in : raw asynchronous pins
//   rise_en     : per-bit rising-edge interrupt enable
//   fall_en     : per-bit falling-edge interrupt enable
//   irq_clr     : per-bit clear of irq_status (set wins over clear)
//   gpio_clean  : debounced levels (feeds gpio_port_in of the GPIO MMIO block)
//   rise_pulse  : one-cycle pulse per accepted 0->1
//   fall_pulse  : one-cycle pulse per accepted 1->0
//   irq_status  : sticky per-bit edge flags
//   irq_out     : OR of irq_status
module risc_v_mike_gpio_debounce
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GPIO_BYTE-1:0] gpio_pin_in,
  input  logic [GPIO_BYTE-1:0] rise_en,
  input  logic [GPIO_BYTE-1:0] fall_en,
  input  logic [GPIO_BYTE-1:0] irq_clr,
  output logic [GPIO_BYTE-1:0] gpio_clean,
  output logic [GPIO_BYTE-1:0] rise_pulse,
  output logic [GPIO_BYTE-1:0] fall_pulse,
  output logic [GPIO_BYTE-1:0] irq_status,
  output logic                 irq_out
);

  logic [GPIO_BYTE-1:0] irq_set;

  for (genvar i = 0; i < GPIO_BYTE; i++) begin : g_bit
    risc_v_mike_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .pin_in     (gpio_pin_in[i]),
      .clean      (gpio_clean[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign irq_set = (rise_pulse & rise_en) | (fall_pulse & fall_en);

  // Set has priority: a clear landing on the same edge as a new event keeps
  // the flag so the event is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_set;
    end
  end

  assign irq_out = |irq_status;

endmodule

// File: tb/tb_risc_v_mike_gpio_debounce.sv
// Self-checking bench for risc_v_mike_gpio_debounce (DEBOUNCE_CYCLES = 4).
module tb_risc_v_mike_gpio_debounce;
  import risc_v_mike_pkg::*;

  localparam int unsigned D = 4;
  localparam int unsigned W = GPIO_BYTE;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gpio_pin_in = '0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] irq_clr = '0;
  logic [W-1:0] gpio_clean;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] irq_status;
  logic         irq_out;

  int tests = 0;
  int fails = 0;

  risc_v_mike_gpio_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_pin_in (gpio_pin_in),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .irq_clr     (irq_clr),
    .gpio_clean  (gpio_clean),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .irq_status  (irq_status),
    .irq_out     (irq_out)
  );

  always #5 clk = ~clk;

  // Reference model: a pin level is seen by the debouncer two edges after it
  // is sampled; the clean level flips once the seen level has disagreed with
  // it on D consecutive edges, and the edge pulse is visible in that cycle.
  logic [W-1:0] m_p1 = '0, m_p2 = '0;
  logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_irq = '0;
  int           run [W];

  always @(posedge clk or negedge rst) begin
    logic [W-1:0] n_rise, n_fall;
    if (!rst) begin
      m_p1 = '0; m_p2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_irq = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      m_irq = (m_irq & ~irq_clr) | (m_rise & rise_en) | (m_fall & fall_en);
      n_rise = '0;
      n_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_p2[i] != m_clean[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            m_clean[i] = m_p2[i];
            n_rise[i]  = m_p2[i];
            n_fall[i]  = !m_p2[i];
            run[i]     = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_rise = n_rise;
      m_fall = n_fall;
      m_p2   = m_p1;
      m_p1   = gpio_pin_in;
    end
  end

  // Continuous comparison against the model, once per cycle.
  always @(negedge clk) begin
    tests++;
    if (gpio_clean !== m_clean || rise_pulse !== m_rise || fall_pulse !== m_fall ||
        irq_status !== m_irq || irq_out !== (|m_irq)) begin
      fails++;
      $display("FAIL model t=%0t clean=%h/%h rise=%h/%h fall=%h/%h irq=%h/%h irq_out=%b/%b (got/want)",
               $time, gpio_clean, m_clean, rise_pulse, m_rise, fall_pulse, m_fall,
               irq_status, m_irq, irq_out, |m_irq);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One clock edge; returns 1 time unit after the following falling edge.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int at;
    #1 rst = 1'b0;

    // Reset with random pins: everything stays 0.
    repeat (3) begin
      gpio_pin_in = W'($urandom);
      next();
    end
    chk("rst_clean", 32'(gpio_clean), 32'h0);
    chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
    chk("rst_irq", 32'({irq_status, irq_out}), 32'h0);

    // Pin 0 high across release: rise at edge 6.
    gpio_pin_in = 8'h01;
    rst = 1'b1;
    repeat (5) next();
    chk("rel_clean5", 32'(gpio_clean), 32'h00);
    next();
    chk("rel_clean6", 32'(gpio_clean), 32'h01);
    chk("rel_rise6", 32'(rise_pulse), 32'h01);
    next();
    chk("rel_rise7", 32'(rise_pulse), 32'h00);

    // Glitch on pin 3: three cycles high is too short.
    cnt = 0;
    gpio_pin_in[3] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) gpio_pin_in[3] = 1'b0;
      next();
      if (rise_pulse[3]) cnt++;
    end
    chk("glitch_pulses", 32'(cnt), 32'd0);
    chk("glitch_clean", 32'(gpio_clean[3]), 32'd0);
    chk("glitch_irq", 32'(irq_status[3]), 32'd0);

    // Edge IRQ: falling not enabled, rising enabled.
    rise_en = 8'h01;
    fall_en = 8'h00;
    gpio_pin_in[0] = 1'b0;
    repeat (6) next();
    chk("fall_pulse0", 32'(fall_pulse), 32'h01);
    next();
    chk("fall_noirq", 32'(irq_status), 32'h00);
    gpio_pin_in[0] = 1'b1;
    repeat (6) next();
    chk("rise_pulse0", 32'(rise_pulse), 32'h01);
    next();
    chk("rise_irq", 32'(irq_status), 32'h01);
    chk("rise_irq_out", 32'(irq_out), 32'd1);
    chk("rise_once", 32'(rise_pulse), 32'h00);
    rise_en = 8'h00;
    repeat (3) next();
    chk("irq_sticky", 32'(irq_status), 32'h01);
    rise_en = 8'h01;

    // Clear, then set/clear collision.
    irq_clr = 8'h01;
    next();
    irq_clr = 8'h00;
    chk("clr_alone", 32'(irq_status), 32'h00);
    gpio_pin_in[0] = 1'b0;
    repeat (8) next();
    gpio_pin_in[0] = 1'b1;
    repeat (6) next();
    chk("coll_rise", 32'(rise_pulse[0]), 32'd1);
    irq_clr = 8'h01;
    next();
    irq_clr = 8'h00;
    chk("coll_keep", 32'(irq_status[0]), 32'd1);
    irq_clr = 8'h01;
    next();
    irq_clr = 8'h00;
    chk("coll_clr", 32'(irq_status[0]), 32'd0);

    // Independence: pin 1 then pin 7 two cycles later.
    gpio_pin_in[1] = 1'b1;
    next();
    next();
    gpio_pin_in[7] = 1'b1;
    repeat (3) next();
    chk("ind_b1_5", 32'(gpio_clean[1]), 32'd0);
    next();
    chk("ind_b1_6", 32'(gpio_clean[1]), 32'd1);
    chk("ind_b7_4", 32'(gpio_clean[7]), 32'd0);
    next();
    chk("ind_b7_5", 32'(gpio_clean[7]), 32'd0);
    next();
    chk("ind_b7_6", 32'(gpio_clean[7]), 32'd1);

    // Reset mid-count on pin 2.
    gpio_pin_in[2] = 1'b1;
    repeat (4) next();
    rst = 1'b0;
    next();
    chk("midrst_clean", 32'(gpio_clean), 32'h00);
    rst = 1'b1;
    cnt = 0;
    at = 0;
    for (int k = 1; k <= 10; k++) begin
      next();
      if (rise_pulse[2]) begin
        cnt++;
        at = k;
      end
    end
    chk("midrst_count", 32'(cnt), 32'd1);
    chk("midrst_edge", 32'(at), 32'd6);

    // Randomized traffic with sticky pin changes, random enables/clears and
    // occasional resets; the model comparison runs every cycle.
    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] flip;
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 7) == 0);
      if (k % 64 == 0) begin
        rise_en = W'($urandom);
        fall_en = W'($urandom);
      end
      gpio_pin_in = gpio_pin_in ^ flip;
      irq_clr = W'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 399) != 0);
      next();
    end
    rst = 1'b1;
    irq_clr = '0;
    repeat (4) next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
